// File: rtl/riscv_pkg.sv
// Shared core-wide constants for the RISC-V pipeline: datapath width,
// bubble encoding and instruction size.
package riscv_pkg;
  localparam int          XLEN       = 64;
  localparam logic [31:0] NOP_INST   = 32'h0000_0013;  // addi x0,x0,0
  localparam int          INST_BYTES = 4;
endpackage

// File: rtl/instruction_fetch_stage_if.sv
// Fetch-stage bus: memory address/data, hazard/redirect controls and the IF/ID outputs.
interface instruction_fetch_stage_if #(parameter int XLEN = riscv_pkg::XLEN);
  logic            stall;
  logic            branch_taken;
  logic [XLEN-1:0] branch_target;
  logic [XLEN-1:0] Inst_Address;
  logic [31:0]     Instruction;
  logic [XLEN-1:0] ifid_pc;
  logic [31:0]     ifid_inst;
  logic            ifid_valid;

  modport master (
    input  stall, branch_taken, branch_target, Instruction,
    output Inst_Address, ifid_pc, ifid_inst, ifid_valid
  );

  modport slave (
    output stall, branch_taken, branch_target, Instruction,
    input  Inst_Address, ifid_pc, ifid_inst, ifid_valid
  );
endinterface

// File: rtl/pc_register.sv
// Program counter: reset > load > hold > advance by one instruction (modular).
module pc_register
  import riscv_pkg::*;
#(
  parameter int              XLEN     = riscv_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            hold,
  input  logic            load,
  input  logic [XLEN-1:0] load_value,
  output logic [XLEN-1:0] pc
);
  always_ff @(posedge clk) begin
    if (reset)      pc <= RESET_PC;
    else if (load)  pc <= load_value;
    else if (!hold) pc <= pc + XLEN'(INST_BYTES);
  end
endmodule

// File: rtl/instruction_fetch_stage.sv
// IF stage: owns the PC, drives the fetch address and registers the fetched
// word with its PC into IF/ID, bubbling on redirect and past end-of-program.
module instruction_fetch_stage
  import riscv_pkg::*;
#(
  parameter int              XLEN     = riscv_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter logic [XLEN-1:0] PC_LIMIT = XLEN'(12),
  parameter logic [31:0]     NOP_INST = riscv_pkg::NOP_INST
) (
  input  logic                       clk,
  input  logic                       reset,
  instruction_fetch_stage_if.master  io
);
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] redirect_pc;
  logic            in_range;
  logic [31:0]     fetched;

  // Targets are forced word-aligned; no misalign trap is raised.
  assign redirect_pc = {io.branch_target[XLEN-1:2], 2'b00};

  pc_register #(.XLEN(XLEN), .RESET_PC(RESET_PC)) u_pc (
    .clk        (clk),
    .reset      (reset),
    .hold       (io.stall),
    .load       (io.branch_taken),
    .load_value (redirect_pc),
    .pc         (pc)
  );

  assign io.Inst_Address = pc;

  // Reads past the loaded image are never trusted; they become bubbles.
  assign in_range = (pc < PC_LIMIT);
  assign fetched  = in_range ? io.Instruction : NOP_INST;

  always_ff @(posedge clk) begin
    if (reset) begin
      io.ifid_pc    <= '0;
      io.ifid_inst  <= NOP_INST;
      io.ifid_valid <= 1'b0;
    end else if (io.branch_taken) begin
      io.ifid_pc    <= pc;
      io.ifid_inst  <= NOP_INST;
      io.ifid_valid <= 1'b0;
    end else if (!io.stall) begin
      io.ifid_pc    <= pc;
      io.ifid_inst  <= fetched;
      io.ifid_valid <= in_range;
    end
  end
endmodule
